// File: rtl/regfile_8x4.sv
// 8 x 4-bit register file: one synchronous write port, one combinational read
// port on the same address, synchronous bulk clear and asynchronous reset.
module regfile_8x4 #(
    parameter int DATA_WIDTH = 4,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // clr wins over load, so a write issued on a clearing edge is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (load) begin
            mem[addr] <= din;
        end
    end

    // Reads the stored entry only, so a pending write is not visible before its edge.
    assign q = mem[addr];

endmodule

// File: tb/tb_regfile_8x4.sv
// Directed and model-based bench for regfile_8x4; a negedge monitor compares q
// against the expected values queued by the driver tasks.
module tb_regfile_8x4;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       clr;
    logic [2:0] addr;
    logic [3:0] din;
    logic [3:0] q;

    logic [3:0] exp_q[$];
    string      name_q[$];
    logic       chk_en;
    logic [3:0] model [8];
    int         n_cmp;
    int         n_err;

    regfile_8x4 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .clr  (clr),
        .addr (addr),
        .din  (din),
        .q    (q)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst_n = 1'b0;
        chk_en = 1'b0;
        n_cmp = 0;
        n_err = 0;
        addr = '0;
        din = '0;
        // load/clr deliberately left undriven during the first reset
        #12;
        load = 1'b0;
        clr = 1'b0;
        #10;
        rst_n = 1'b1;
    end

    // monitor / scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL no_expected: q=%h with empty expected queue", q);
            end else begin
                logic [3:0] e;
                string      nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_cmp++;
                if (q !== e) begin
                    n_err++;
                    $display("FAIL %s: addr=%0d got q=%h expected %h", nm, addr, q, e);
                end
            end
        end
    end

    // driver tasks
    task automatic expect_q(input string nm, input logic [3:0] e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        chk_en = 1'b1;
        @(negedge clk);
        #1;
        chk_en = 1'b0;
    endtask

    task automatic read_check(input string nm, input logic [2:0] a);
        @(posedge clk);
        #1;
        load = 1'b0;
        clr  = 1'b0;
        addr = a;
        expect_q(nm, model[a]);
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d, input bit chk_old);
        @(posedge clk);
        #1;
        load = 1'b1;
        clr  = 1'b0;
        addr = a;
        din  = d;
        if (chk_old) expect_q("no_write_through", model[a]);
        @(posedge clk);
        #1;
        load = 1'b0;
        model[a] = d;
    endtask

    task automatic do_clear(input bit with_load, input logic [2:0] a, input logic [3:0] d);
        @(posedge clk);
        #1;
        clr  = 1'b1;
        load = with_load;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        clr  = 1'b0;
        load = 1'b0;
        for (int i = 0; i < 8; i++) model[i] = 4'h0;
    endtask

    task automatic sweep(input string nm);
        for (int i = 0; i < 8; i++) read_check(nm, 3'(i));
    endtask

    // stimulus
    initial begin
        for (int i = 0; i < 8; i++) model[i] = 4'h0;
        wait (rst_n === 1'b1);

        sweep("reset_zero");

        // base 0x1: entry i holds 0x1+i; q checked right after the write edge
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 4'(4'h1 + i), 1'b0);
            expect_q("write_base1", 4'(4'h1 + i));
        end
        // base 0x8: entry 7 reaches 0xF; also verify q holds the old value pre-edge
        for (int i = 0; i < 8; i++) begin
            do_write(3'(i), 4'(4'h8 + i), 1'b1);
            expect_q("write_base8", 4'(4'h8 + i));
        end
        sweep("hold_after_writes");

        do_clear(1'b0, 3'd0, 4'h0);
        sweep("clear_zero");

        do_write(3'd3, 4'h6, 1'b0);
        read_check("pre_clr_prio", 3'd3);
        do_clear(1'b1, 3'd3, 4'hA);
        read_check("clr_over_load", 3'd3);

        // directed hold: load=0 must leave entries untouched
        do_write(3'd5, 4'hC, 1'b0);
        @(posedge clk);
        #1;
        din = 4'h3;
        addr = 3'd5;
        read_check("hold_no_load", 3'd5);

        for (int k = 0; k < 32; k++) begin
            do_write(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 1'b0);
            read_check("random_rw", 3'($urandom_range(0, 7)));
        end

        // asynchronous reset between clock edges
        do_write(3'd2, 4'h5, 1'b0);
        read_check("pre_async_rst", 3'd2);
        @(posedge clk);
        #2;
        addr  = 3'd2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (q !== 4'h0) begin
            n_err++;
            $display("FAIL async_reset_immediate: got q=%h expected 0", q);
        end
        for (int i = 0; i < 8; i++) model[i] = 4'h0;
        expect_q("async_reset_negedge", 4'h0);
        rst_n = 1'b1;
        sweep("after_async_rst");
        do_write(3'd2, 4'h9, 1'b0);
        read_check("write_after_rst", 3'd2);

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // global time bound
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "timeout");
    end

endmodule
